// File: rtl/dechat_scan_pkg.sv
// rtl/dechat_scan_pkg.sv - shared types, widths and round-robin search for dechat_scan
// Contents:
//   state_t  : arbiter state (ST_IDLE, ST_PRESENT)
//   NCH_MAX  : largest supported channel count
//   CHW_MAX  : channel-index width at NCH_MAX
//   rr_pick  : first set request searching upward from last+1, with wrap
package dechat_scan_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam int NCH_MAX = 16;
    localparam int CHW_MAX = $clog2(NCH_MAX);

    // req is zero-extended to NCH_MAX; only the low nch bits are searched.
    // Returns 0 when nothing is requested; callers only use it with |req.
    function automatic int rr_pick(input logic [NCH_MAX-1:0] req,
                                   input int last,
                                   input int nch);
        int   idx;
        int   sel;
        logic found;
        sel   = 0;
        found = 1'b0;
        for (int i = 1; i <= NCH_MAX; i++) begin
            idx = (last + i) % nch;
            if (!found && (i <= nch) && req[idx[CHW_MAX-1:0]]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/dechat_tick_ch.sv
// rtl/dechat_tick_ch.sv - one debounce channel: synchroniser, tick counter, level and edge pulse
// Ports:
//   CLK, RSTX  : clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   tick       : shared prescaled tick
//   timeout    : ticks of stable mismatch required before level changes
//   level      : debounced level
//   edge_stb   : one-cycle pulse in the cycle level changes
//   edge_rise  : direction of the last change (1 = rising), valid with edge_stb
module dechat_tick_ch #(
    parameter int   CBW = 4,
    parameter logic RV  = 1'b0
) (
    input  logic           CLK,
    input  logic           RSTX,
    input  logic           din,
    input  logic           tick,
    input  logic [CBW-1:0] timeout,
    output logic           level,
    output logic           edge_stb,
    output logic           edge_rise
);
    import dechat_scan_pkg::*;

    logic           sync1;
    logic           sync2;
    logic [CBW-1:0] cnt;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            sync1     <= RV;
            sync2     <= RV;
            level     <= RV;
            cnt       <= '0;
            edge_stb  <= 1'b0;
            edge_rise <= 1'b0;
        end else begin
            sync1    <= din;
            sync2    <= sync1;
            edge_stb <= 1'b0;
            if (sync2 == level) begin
                // any return to the current level restarts the wait
                cnt <= '0;
            end else if (cnt >= timeout) begin
                // compare happens before the tick increment, so timeout 0
                // follows the synchroniser on the next cycle without a tick
                level     <= sync2;
                cnt       <= '0;
                edge_stb  <= 1'b1;
                edge_rise <= sync2;
            end else if (tick && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dechat_scan.sv
// rtl/dechat_scan.sv - multi-channel debounce with shared prescaler and round-robin event port
// Build option: DECHAT_SCAN_FALL_EN - when defined, falling edges also create events;
//               otherwise only rising edges do and EV_RISE is constant 1.
// Ports:
//   CLK, RSTX  : clock, asynchronous active-low reset
//   DIN        : raw asynchronous inputs, one per channel
//   PRESCALE   : tick period minus 1, in CLK cycles
//   TIMEOUT    : ticks of stable mismatch required before LEVEL changes
//   LEVEL      : debounced levels
//   EV_VALID   : event presented; held until EV_READY
//   EV_READY   : consumer accepts the event
//   EV_CH      : channel of the presented event
//   EV_RISE    : 1 = rising edge, 0 = falling edge
//   OVF        : sticky, an event was merged into a still-pending one
module dechat_scan
    import dechat_scan_pkg::*;
#(
    parameter int   NCH = 4,
    parameter int   PBW = 16,
    parameter int   CBW = 4,
    parameter logic RV  = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RSTX,
    input  logic [NCH-1:0]         DIN,
    input  logic [PBW-1:0]         PRESCALE,
    input  logic [CBW-1:0]         TIMEOUT,
    output logic [NCH-1:0]         LEVEL,
    output logic                   EV_VALID,
    input  logic                   EV_READY,
    output logic [$clog2(NCH)-1:0] EV_CH,
    output logic                   EV_RISE,
    output logic                   OVF
);

    localparam int CW = $clog2(NCH);

    logic [PBW-1:0]     pcnt;
    logic               tick;
    logic [NCH-1:0]     edge_stb;
    logic [NCH-1:0]     edge_rise;
    logic [NCH-1:0]     ev_in;
    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     clr;
    logic [NCH_MAX-1:0] pend_ext;
    logic [CW-1:0]      rr;
    logic [CW-1:0]      pick;
    logic               grant;
    state_t             state;

    // A PRESCALE lowered below pcnt simply lets pcnt run round through 2^PBW.
    assign tick = (pcnt == PRESCALE);

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dechat_tick_ch #(
            .CBW (CBW),
            .RV  (RV)
        ) u_ch (
            .CLK       (CLK),
            .RSTX      (RSTX),
            .din       (DIN[g]),
            .tick      (tick),
            .timeout   (TIMEOUT),
            .level     (LEVEL[g]),
            .edge_stb  (edge_stb[g]),
            .edge_rise (edge_rise[g])
        );
    end

`ifdef DECHAT_SCAN_FALL_EN
    logic [NCH-1:0] pol;
    assign ev_in = edge_stb;
`else
    assign ev_in   = edge_stb & edge_rise;
    assign EV_RISE = 1'b1;
`endif

    assign pend_ext = NCH_MAX'(pend);
    assign pick     = CW'(rr_pick(pend_ext, int'(rr), NCH));
    assign grant    = (state == ST_IDLE) && (|pend);

    always_comb begin
        clr = '0;
        if (grant) begin
            clr[pick] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state    <= ST_IDLE;
            pend     <= '0;
            rr       <= CW'(NCH - 1);
            EV_VALID <= 1'b0;
            EV_CH    <= '0;
            OVF      <= 1'b0;
`ifdef DECHAT_SCAN_FALL_EN
            pol      <= '0;
            EV_RISE  <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ev_in[i]) begin
                    // a new edge beats a same-cycle grant: it is queued again
                    pend[i] <= 1'b1;
`ifdef DECHAT_SCAN_FALL_EN
                    pol[i]  <= edge_rise[i];
`endif
                    if (pend[i] && !clr[i]) begin
                        OVF <= 1'b1;
                    end
                end else if (clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        EV_CH    <= pick;
                        rr       <= pick;
                        EV_VALID <= 1'b1;
                        state    <= ST_PRESENT;
`ifdef DECHAT_SCAN_FALL_EN
                        EV_RISE  <= pol[pick];
`endif
                    end
                end
                ST_PRESENT: begin
                    if (EV_READY) begin
                        EV_VALID <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dechat_scan.sv
// tb/tb_dechat_scan.sv - self-checking bench for dechat_scan
module tb_dechat_scan;

    localparam int NCH = 4;
    localparam int PBW = 16;
    localparam int CBW = 4;

    logic           CLK;
    logic           RSTX;
    logic [NCH-1:0] DIN;
    logic [PBW-1:0] PRESCALE;
    logic [CBW-1:0] TIMEOUT;
    logic [NCH-1:0] LEVEL;
    logic           EV_VALID;
    logic           EV_READY;
    logic [1:0]     EV_CH;
    logic           EV_RISE;
    logic           OVF;

    int n_pass  = 0;
    int n_total = 0;

    int hs_ch[$];
    int hs_cyc[$];

`ifdef DECHAT_SCAN_FALL_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    dechat_scan #(.NCH(NCH), .PBW(PBW), .CBW(CBW), .RV(1'b0)) dut (
        .CLK      (CLK),
        .RSTX     (RSTX),
        .DIN      (DIN),
        .PRESCALE (PRESCALE),
        .TIMEOUT  (TIMEOUT),
        .LEVEL    (LEVEL),
        .EV_VALID (EV_VALID),
        .EV_READY (EV_READY),
        .EV_CH    (EV_CH),
        .EV_RISE  (EV_RISE),
        .OVF      (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic do_reset();
        @(negedge CLK);
        RSTX     = 1'b0;
        DIN      = '0;
        EV_READY = 1'b0;
        PRESCALE = '0;
        TIMEOUT  = '0;
        repeat (3) @(negedge CLK);
        RSTX = 1'b1;
        @(negedge CLK);
    endtask

    // records every handshake (EV_VALID with EV_READY held at 1) over ncyc cycles
    task automatic collect(input int ncyc);
        hs_ch.delete();
        hs_cyc.delete();
        EV_READY = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            if (EV_VALID && EV_READY) begin
                hs_ch.push_back(int'(EV_CH));
                hs_cyc.push_back(c);
            end
        end
    endtask

    task automatic test_reset();
        RSTX     = 1'b0;
        DIN      = 4'b1111;
        EV_READY = 1'b0;
        PRESCALE = '0;
        TIMEOUT  = '0;
        repeat (4) @(negedge CLK);
        n_total++; if (LEVEL !== 4'b0000) $display("FAIL reset_level got %b want 0000", LEVEL); else n_pass++;
        n_total++; if (EV_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", EV_VALID); else n_pass++;
        n_total++; if (EV_CH !== 2'd0) $display("FAIL reset_ch got %0d want 0", EV_CH); else n_pass++;
        n_total++; if (OVF !== 1'b0) $display("FAIL reset_ovf got %b want 0", OVF); else n_pass++;
        n_total++; if (EV_RISE !== !FALL_EN) $display("FAIL reset_rise got %b want %b", EV_RISE, !FALL_EN); else n_pass++;
        DIN = '0;
        @(negedge CLK);
        RSTX = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_latency();
        logic [2:0] seen;
        int         wait_n;
        logic       held;
        do_reset();
        DIN = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            seen[k] = LEVEL[1];
        end
        n_total++; if (seen !== 3'b100) $display("FAIL latency_level1 got %b want 100 (cycles 3..1)", seen); else n_pass++;
        wait_n = 0;
        while (!EV_VALID && wait_n < 10) begin
            @(negedge CLK);
            wait_n++;
        end
        n_total++; if (EV_VALID !== 1'b1) $display("FAIL latency_event got valid=%b want 1 within 10 cycles", EV_VALID); else n_pass++;
        n_total++; if (EV_CH !== 2'd1 || EV_RISE !== 1'b1) $display("FAIL latency_event_fields got ch=%0d rise=%b want ch=1 rise=1", EV_CH, EV_RISE); else n_pass++;
        held = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (!(EV_VALID === 1'b1 && EV_CH === 2'd1)) held = 1'b0;
        end
        n_total++; if (held !== 1'b1) $display("FAIL latency_hold got held=%b want 1", held); else n_pass++;
        EV_READY = 1'b1;
        @(negedge CLK);
        EV_READY = 1'b0;
        n_total++; if (EV_VALID !== 1'b0) $display("FAIL latency_handshake got valid=%b want 0", EV_VALID); else n_pass++;
    endtask

    task automatic test_glitch();
        logic bad;
        int   rise_at;
        do_reset();
        PRESCALE = 16'd9;
        TIMEOUT  = 4'd3;
        EV_READY = 1'b0;
        bad = 1'b0;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 25; c++) begin
                DIN[0] = (c < 20);
                @(negedge CLK);
                if (LEVEL[0] !== 1'b0 || EV_VALID !== 1'b0) bad = 1'b1;
            end
        end
        n_total++; if (bad !== 1'b0) $display("FAIL glitch_suppressed got change=%b want 0", bad); else n_pass++;
        DIN[0]  = 1'b1;
        rise_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (rise_at < 0 && LEVEL[0] === 1'b1) rise_at = c;
        end
        n_total++; if (rise_at < 0) $display("FAIL glitch_release got no rise want rise within 40 cycles"); else n_pass++;
        n_total++; if (rise_at >= 0 && rise_at < 20) $display("FAIL glitch_early got rise at %0d want >= 20", rise_at); else n_pass++;
    endtask

    task automatic test_burst();
        logic ok;
        do_reset();
        DIN = 4'b1111;
        collect(30);
        n_total++; if (hs_ch.size() != 4) $display("FAIL burst_count got %0d want 4", hs_ch.size()); else n_pass++;
        ok = (hs_ch.size() == 4);
        for (int i = 0; i < hs_ch.size() && i < 4; i++) if (hs_ch[i] != i) ok = 1'b0;
        n_total++; if (ok !== 1'b1) $display("FAIL burst_order got %p want 0 1 2 3", hs_ch); else n_pass++;
        ok = (hs_cyc.size() == 4);
        for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 2) ok = 1'b0;
        n_total++; if (ok !== 1'b1) $display("FAIL burst_spacing got %p want gaps of 2", hs_cyc); else n_pass++;

        do_reset();
        DIN = 4'b0010;
        collect(15);
        n_total++; if (hs_ch.size() != 1 || hs_ch[0] != 1) $display("FAIL rr_first got %p want 1", hs_ch); else n_pass++;
        DIN = 4'b1011;
        collect(15);
        ok = (hs_ch.size() == 2) && (hs_ch[0] == 3) && (hs_ch[1] == 0);
        n_total++; if (ok !== 1'b1) $display("FAIL rr_wrap got %p want 3 0", hs_ch); else n_pass++;
    endtask

    task automatic test_ovf();
        do_reset();
        EV_READY = 1'b0;
        for (int r = 0; r < 3; r++) begin
            DIN[2] = 1'b1;
            repeat (6) @(negedge CLK);
            if (r < 2) begin
                DIN[2] = 1'b0;
                repeat (6) @(negedge CLK);
            end
        end
        n_total++; if (EV_VALID !== 1'b1 || EV_CH !== 2'd2 || EV_RISE !== 1'b1) $display("FAIL ovf_present got v=%b ch=%0d rise=%b want v=1 ch=2 rise=1", EV_VALID, EV_CH, EV_RISE); else n_pass++;
        n_total++; if (OVF !== 1'b1) $display("FAIL ovf_set got %b want 1", OVF); else n_pass++;
        EV_READY = 1'b1;
        repeat (10) @(negedge CLK);
        n_total++; if (OVF !== 1'b1) $display("FAIL ovf_sticky got %b want 1", OVF); else n_pass++;
        RSTX = 1'b0;
        #1;
        n_total++; if (OVF !== 1'b0) $display("FAIL ovf_reset got %b want 0", OVF); else n_pass++;
        @(negedge CLK);
        RSTX = 1'b1;
    endtask

    task automatic test_fall();
        int found;
        do_reset();
        DIN = 4'b1000;
        collect(15);
        EV_READY = 1'b0;
        DIN      = 4'b0000;
        found    = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (EV_VALID) found = 1;
        end
        if (FALL_EN) begin
            n_total++; if (found != 1 || EV_CH !== 2'd3 || EV_RISE !== 1'b0) $display("FAIL fall_event got found=%0d ch=%0d rise=%b want 1 3 0", found, EV_CH, EV_RISE); else n_pass++;
        end else begin
            n_total++; if (found != 0) $display("FAIL fall_none got found=%0d want 0", found); else n_pass++;
        end
        n_total++; if (LEVEL[3] !== 1'b0) $display("FAIL fall_level got %b want 0", LEVEL[3]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic stale;
        do_reset();
        EV_READY = 1'b0;
        DIN      = 4'b1111;
        repeat (10) @(negedge CLK);
        n_total++; if (EV_VALID !== 1'b1) $display("FAIL mid_precond got valid=%b want 1", EV_VALID); else n_pass++;
        RSTX = 1'b0;
        #1;
        n_total++; if (EV_VALID !== 1'b0 || LEVEL !== 4'b0000 || OVF !== 1'b0) $display("FAIL mid_reset got v=%b lvl=%b ovf=%b want 0 0000 0", EV_VALID, LEVEL, OVF); else n_pass++;
        DIN = 4'b0000;
        repeat (2) @(negedge CLK);
        RSTX  = 1'b1;
        stale = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (EV_VALID !== 1'b0) stale = 1'b1;
        end
        n_total++; if (stale !== 1'b0) $display("FAIL mid_stale got %b want 0", stale); else n_pass++;
    endtask

    // Reference: LEVEL is DIN delayed by 3 cycles (TIMEOUT 0); every change of
    // that delayed value is one expected event, counted per channel and direction.
    task automatic test_random();
        logic [NCH-1:0] dq[$];
        logic [NCH-1:0] exp_lvl;
        logic [NCH-1:0] prev_lvl;
        int exp_rise[NCH];
        int exp_fall[NCH];
        int obs_rise[NCH];
        int obs_fall[NCH];
        int last_tog[NCH];
        int lvl_err;
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            exp_rise[i] = 0; exp_fall[i] = 0; obs_rise[i] = 0; obs_fall[i] = 0; last_tog[i] = 0;
        end
        repeat (3) dq.push_back('0);
        prev_lvl = '0;
        lvl_err  = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge CLK);
            exp_lvl = dq[dq.size() - 3];
            if (LEVEL !== exp_lvl) begin
                if (lvl_err == 0) $display("random level at cycle %0d: got %b expected %b", c, LEVEL, exp_lvl);
                lvl_err++;
            end
            for (int i = 0; i < NCH; i++) begin
                if (exp_lvl[i] && !prev_lvl[i]) exp_rise[i]++;
                if (!exp_lvl[i] && prev_lvl[i]) exp_fall[i]++;
            end
            prev_lvl = exp_lvl;
            if (c < 640) begin
                for (int i = 0; i < NCH; i++) begin
                    if (c - last_tog[i] >= 40 && $urandom_range(0, 9) == 0) begin
                        DIN[i]      = ~DIN[i];
                        last_tog[i] = c;
                    end
                end
                EV_READY = ($urandom_range(0, 7) != 0);
            end else begin
                EV_READY = 1'b1;
            end
            dq.push_back(DIN);
            if (EV_VALID && EV_READY) begin
                if (EV_RISE) obs_rise[EV_CH]++;
                else obs_fall[EV_CH]++;
            end
        end
        n_total++; if (lvl_err != 0) $display("FAIL random_level got %0d mismatching cycles want 0", lvl_err); else n_pass++;
        for (int i = 0; i < NCH; i++) begin
            n_total++; if (obs_rise[i] != exp_rise[i]) $display("FAIL random_rise ch%0d got %0d want %0d", i, obs_rise[i], exp_rise[i]); else n_pass++;
            n_total++; if (obs_fall[i] != (FALL_EN ? exp_fall[i] : 0)) $display("FAIL random_fall ch%0d got %0d want %0d", i, obs_fall[i], FALL_EN ? exp_fall[i] : 0); else n_pass++;
        end
        n_total++; if (OVF !== 1'b0) $display("FAIL random_ovf got %b want 0", OVF); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_burst();
        test_ovf();
        test_fall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
